uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8 data bits, parity, 1 stop bit) among N_REQ byte requesters using round-robin arbitration.
- Latches the winning byte and its parity mode, then pulses the transmitter start.
- Waits for the frame to complete, then enforces a minimum idle gap before the next grant.
- Sits between the internal byte sources and the UART TX serializer, mirroring the receive path on the line side.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, line constants used by the
// transmitter, receiver and TX arbiter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_e;

    localparam int BAUD_DIV  = 40;
    localparam int DATA_BITS = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after rr_ptr,
// wrapping modulo N_REQ, so the last winner always has lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    // scan N_REQ positions starting one past the previous winner
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!grant_vld && req[(int'(rr_ptr) + off) % N_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'((int'(rr_ptr) + off) % N_REQ);
                grant_oh[(int'(rr_ptr) + off) % N_REQ] = 1'b1;
            end else begin
                grant_vld = grant_vld;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte sources:
// grant/latch, start pulse, frame supervision with timeout, post-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 40
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [DATA_BITS*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]           req_parity_odd,
    output logic [N_REQ-1:0]           ack,
    output logic                       tx_start,
    output logic [DATA_BITS-1:0]       tx_data,
    output logic                       tx_parity_odd,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int TIMER_W = $clog2(max_int(TIMEOUT_CYC, GAP_CYC) + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYC - 1);
    // with no gap configured a finished or abandoned frame returns straight to IDLE
    localparam arb_state_e POST_FRAME = (GAP_CYC == 0) ? IDLE : GAP;

    arb_state_e             state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_parity_odd_q, tx_parity_odd_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic                   tx_start_q, tx_start_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   busy_q, busy_d;

    logic [N_REQ-1:0]       win_oh_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_vld_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (win_oh_s),
        .grant_idx (win_idx_s),
        .grant_vld (win_vld_s)
    );

    // next-state, latch and pulse generation
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        rr_ptr_d        = rr_ptr_q;
        tx_data_d       = tx_data_q;
        tx_parity_odd_d = tx_parity_odd_q;
        grant_idx_d     = grant_idx_q;
        ack_d           = '0;
        tx_start_d      = 1'b0;
        err_timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld_s) begin
                    tx_data_d       = req_data[{win_idx_s, 3'b000} +: DATA_BITS];
                    tx_parity_odd_d = req_parity_odd[win_idx_s];
                    grant_idx_d     = win_idx_s;
                    rr_ptr_d        = win_idx_s;
                    ack_d           = win_oh_s;
                    state_d         = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                tx_start_d = 1'b1;
                timer_d    = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tx_done) begin
                    // frame shorter than one cycle of busy: already complete
                    timer_d = '0;
                    state_d = POST_FRAME;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_timeout_d = 1'b1;
                    timer_d       = '0;
                    state_d       = POST_FRAME;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    timer_d = '0;
                    state_d = POST_FRAME;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            rr_ptr_q        <= IDX_W'(N_REQ - 1);
            tx_data_q       <= 8'h00;
            tx_parity_odd_q <= 1'b0;
            grant_idx_q     <= '0;
            ack_q           <= '0;
            tx_start_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            rr_ptr_q        <= rr_ptr_d;
            tx_data_q       <= tx_data_d;
            tx_parity_odd_q <= tx_parity_odd_d;
            grant_idx_q     <= grant_idx_d;
            ack_q           <= ack_d;
            tx_start_q      <= tx_start_d;
            err_timeout_q   <= err_timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign ack           = ack_q;
    assign tx_start      = tx_start_q;
    assign tx_data       = tx_data_q;
    assign tx_parity_odd = tx_parity_odd_q;
    assign grant_idx     = grant_idx_q;
    assign busy          = busy_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued by the
// stimulus and checked by a monitor whenever ack pulses.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 20;   // model busy length; tx_done lands FRAME cycles after tx_start

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req, req_odd, ack;
    logic [31:0] req_data;
    logic        tx_busy, tx_done, tx_start, tx_parity_odd, busy, err_timeout;
    logic [7:0]  tx_data;
    logic [1:0]  grant_idx;
    logic        model_en;

    logic [3:0]  g_req, g_odd, g_ack;
    logic [31:0] g_data;
    logic        g_busy_in, g_done, g_start, g_par, g_busy, g_err;
    logic [7:0]  g_txd;
    logic [1:0]  g_idx;

    uart_tx_arbiter #(.N_REQ(4), .IDX_W(2), .TIMEOUT_CYC(64), .GAP_CYC(40)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .req_parity_odd(req_odd), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
        .tx_parity_odd(tx_parity_odd), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_idx(grant_idx), .busy(busy), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.N_REQ(4), .IDX_W(2), .TIMEOUT_CYC(64), .GAP_CYC(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(g_req), .req_data(g_data),
        .req_parity_odd(g_odd), .ack(g_ack), .tx_start(g_start), .tx_data(g_txd),
        .tx_parity_odd(g_par), .tx_busy(g_busy_in), .tx_done(g_done),
        .grant_idx(g_idx), .busy(g_busy), .err_timeout(g_err)
    );

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;
    int start_cnt = 0;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        logic       odd;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] data, input logic odd);
        exp_t e;
        e.idx = idx; e.data = data; e.odd = odd;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0000 && n < maxc);
        chk("wait_ack", {31'd0, ack != 4'b0000}, 32'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // transmitter model for the main DUT
    initial begin
        int cnt;
        cnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!reset_n) begin
                tx_busy = 1'b0; cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin tx_busy = 1'b0; tx_done = 1'b1; end
            end else if (tx_start && model_en) begin
                tx_busy = 1'b1; cnt = FRAME;
            end
        end
    end

    // transmitter model for the zero-gap DUT
    initial begin
        int cnt;
        cnt = 0; g_busy_in = 1'b0; g_done = 1'b0;
        forever begin
            @(negedge clk);
            g_done = 1'b0;
            if (!reset_n) begin
                g_busy_in = 1'b0; cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin g_busy_in = 1'b0; g_done = 1'b1; end
            end else if (g_start) begin
                g_busy_in = 1'b1; cnt = FRAME;
            end
        end
    end

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start) start_cnt++;
            if (ack != 4'b0000) begin
                ack_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_ack", {28'd0, ack}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_ack", {28'd0, ack}, {28'd0, 4'b0001 << e.idx});
                    chk("sb_data", {24'd0, tx_data}, {24'd0, e.data});
                    chk("sb_parity", {31'd0, tx_parity_odd}, {31'd0, e.odd});
                    chk("sb_grant", {30'd0, grant_idx}, {30'd0, e.idx});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        req = 4'b0000; req_data = 32'h0; req_odd = 4'b0000; model_en = 1'b1;
        g_req = 4'b0000; g_data = 32'h44_33_22_11; g_odd = 4'b0000;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant", {30'd0, grant_idx}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // single request: latency, latch, gap length
        req_data[23:16] = 8'h96; req_odd = 4'b0000;
        push(2'd2, 8'h96, 1'b0);
        req = 4'b0100;
        @(negedge clk);
        chk("t1_ack_latency", {28'd0, ack}, 32'h4);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_start_latency", {31'd0, tx_start}, 32'd1);
        chk("t1_no_overlap", {28'd0, ack}, 32'd0);
        // busy spans START, WAIT_BUSY, FRAME cycles of WAIT_DONE and 40 gap cycles
        n = 2;
        while (n < 300) begin
            @(negedge clk);
            if (busy) n++; else break;
        end
        chk("t1_busy_cycles", n, 2 + FRAME + 40);

        // all four requesting from fresh reset: 0,1,2,3,0
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req_data = 32'h55_69_07_12; req_odd = 4'b0101;
        push(2'd0, 8'h12, 1'b1); push(2'd1, 8'h07, 1'b0); push(2'd2, 8'h69, 1'b1);
        push(2'd3, 8'h55, 1'b0); push(2'd0, 8'h12, 1'b1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_ack(300);
        req = 4'b0000;
        wait_idle(300);

        // last grant 1, then 0 and 1 both pending: alternate without starvation
        req_data[7:0] = 8'hA5; req_data[15:8] = 8'h3C; req_odd = 4'b0010;
        push(2'd1, 8'h3C, 1'b1);
        req = 4'b0010;
        wait_ack(300);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            push(2'd0, 8'hA5, 1'b0);
            push(2'd1, 8'h3C, 1'b1);
        end
        for (int k = 0; k < 8; k++) wait_ack(300);
        req = 4'b0000;
        wait_idle(300);

        // transmitter never goes busy: timeout, gap, next requester, no resend
        model_en = 1'b0;
        req_data[23:16] = 8'h5A; req_odd = 4'b0100;
        push(2'd2, 8'h5A, 1'b1);
        push(2'd0, 8'hA5, 1'b0);
        req = 4'b0100;
        wait_ack(20);
        req = 4'b0001;
        @(negedge clk);
        chk("t4_tx_start", {31'd0, tx_start}, 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!err_timeout && n < 200);
        chk("t4_timeout_dist", n, 64);
        model_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ack == 4'b0000 && n < 200);
        chk("t4_err_to_ack", n, 41);
        req = 4'b0000;
        wait_idle(300);

        // reset during WAIT_DONE with requester 0 still asserting
        req_data[7:0] = 8'hC3; req_odd = 4'b0000;
        push(2'd0, 8'hC3, 1'b0);
        req = 4'b0001;
        wait_ack(20);
        repeat (5) @(negedge clk);
        chk("t5_in_frame", {31'd0, tx_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("t5_rst_ack", {28'd0, ack}, 32'd0);
        repeat (2) @(negedge clk);
        req_data[7:0] = 8'h3E;
        push(2'd0, 8'h3E, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_regrant_ack", {28'd0, ack}, 32'h1);
        req = 4'b0000;
        wait_idle(300);

        // zero-gap build: tx_start spacing = (FRAME+1) frame + 2
        g_req = 4'b0011;
        n = 0;
        do begin @(negedge clk); n++; end while (!g_start && n < 50);
        chk("t6_first_start", {31'd0, g_start}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            int acks;
            n = 0; acks = 0;
            do begin
                @(negedge clk); n++;
                if (g_ack != 4'b0000) acks++;
            end while (!g_start && n < 100);
            chk("t6_start_spacing", n, FRAME + 3);
            chk("t6_one_ack", acks, 1);
        end
        g_req = 4'b0000;
        repeat (40) @(negedge clk);

        chk("sb_queue_empty", sb_q.size(), 0);
        chk("ack_per_start", ack_cnt, start_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
